// File: rtl/press_event_decoder.sv
// Turns the debounced level s into press/release/long-press pulses, a wrapping press count and
// a held level. Define DOUBLE_CLICK_EN to add the double-click window and its pulse output.
module press_event_decoder #(
  parameter int unsigned LONG_CYCLES = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DBL_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  output logic             press,
  output logic             release_p,
  output logic             long_press,
  output logic             held,
  output logic [CNT_W-1:0] count,
  output logic             double_click
);

  localparam int unsigned TimerW = $clog2(LONG_CYCLES + 1);
  // Timer value on the edge before the one that completes a long hold
  localparam logic [TimerW-1:0] LongLast = TimerW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPressed, StLong} state_e;

  state_e            state_q;
  logic              s_q;
  logic [TimerW-1:0] timer_q;

`ifdef DOUBLE_CLICK_EN
  localparam int unsigned WinW = $clog2(DBL_CYCLES + 1);
  // Release edge counts as window edge 1; zero means the window is closed
  localparam logic [WinW-1:0] DblFirst = WinW'((DBL_CYCLES > 1) ? 1 : 0);
  localparam logic [WinW-1:0] DblLast  = WinW'(DBL_CYCLES - 1);

  logic [WinW-1:0] win_q;
`else
  assign double_click = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      s_q        <= 1'b0;
      timer_q    <= '0;
      press      <= 1'b0;
      release_p  <= 1'b0;
      long_press <= 1'b0;
      held       <= 1'b0;
      count      <= '0;
`ifdef DOUBLE_CLICK_EN
      win_q        <= '0;
      double_click <= 1'b0;
`endif
    end else begin
      s_q        <= s;
      press      <= 1'b0;
      release_p  <= 1'b0;
      long_press <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      double_click <= 1'b0;
      if (win_q != '0) begin
        if (s && !s_q) begin
          double_click <= 1'b1;
          win_q        <= '0;
        end else if (win_q >= DblLast) begin
          win_q <= '0;
        end else begin
          win_q <= win_q + 1'b1;
        end
      end
`endif
      unique case (state_q)
        StIdle: begin
          if (s && !s_q) begin
            press   <= 1'b1;
            held    <= 1'b1;
            count   <= count + 1'b1;
            timer_q <= TimerW'(1);
            if (LONG_CYCLES <= 1) begin
              long_press <= 1'b1;
              state_q    <= StLong;
            end else begin
              state_q <= StPressed;
            end
          end
        end
        StPressed: begin
          // A falling edge beats a long threshold landing on the same edge
          if (!s) begin
            release_p <= 1'b1;
            held      <= 1'b0;
            state_q   <= StIdle;
`ifdef DOUBLE_CLICK_EN
            win_q <= DblFirst;
`endif
          end else if (timer_q == LongLast) begin
            long_press <= 1'b1;
            timer_q    <= timer_q + 1'b1;
            state_q    <= StLong;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StLong: begin
          if (!s) begin
            release_p <= 1'b1;
            held      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          held    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_event_decoder.sv
// Self-checking bench: directed scenarios plus random button traffic, compared each cycle
// against an episode-level model of presses, hold lengths and the release window.
module tb_press_event_decoder;

  localparam int unsigned LONG_CYCLES = 4;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned DBL_CYCLES  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s = 1'b0;
  logic             press, release_p, long_press, held, double_click;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  press_event_decoder #(
    .LONG_CYCLES(LONG_CYCLES),
    .CNT_W      (CNT_W),
    .DBL_CYCLES (DBL_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (s),
    .press       (press),
    .release_p   (release_p),
    .long_press  (long_press),
    .held        (held),
    .count       (count),
    .double_click(double_click)
  );

  always #30 clk = ~clk;

  // Model: one press episode at a time, tracked by its hold length in sampled-high edges
  bit m_prev, m_in, m_armed;
  bit m_press, m_rel, m_long, m_dbl;
  int m_run, m_cnt, m_edge, m_relidx;

  task automatic model_reset();
    m_prev = 0; m_in = 0; m_armed = 0;
    m_press = 0; m_rel = 0; m_long = 0; m_dbl = 0;
    m_run = 0; m_cnt = 0; m_edge = 0; m_relidx = 0;
  endtask

  task automatic model_edge(input bit sv);
    m_press = 0; m_rel = 0; m_long = 0; m_dbl = 0;
    m_edge++;
    if (sv && !m_prev) begin
      m_in    = 1;
      m_run   = 1;
      m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      m_press = 1;
      m_long  = (LONG_CYCLES == 1);
`ifdef DOUBLE_CLICK_EN
      if (m_armed && (m_edge - m_relidx + 1) <= DBL_CYCLES) m_dbl = 1;
`endif
      m_armed = 0;
    end else if (m_in && sv) begin
      if (m_run < LONG_CYCLES) begin
        m_run++;
        m_long = (m_run == LONG_CYCLES);
      end
    end else if (m_in && !sv) begin
      m_rel = 1;
      m_in  = 0;
      if (m_run < LONG_CYCLES) begin
        m_armed  = 1;
        m_relidx = m_edge;
      end
    end
    m_prev = sv;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("press", 32'(press), 32'(m_press));
    chk("release_p", 32'(release_p), 32'(m_rel));
    chk("long_press", 32'(long_press), 32'(m_long));
    chk("held", 32'(held), 32'(m_in));
    chk("count", 32'(count), 32'(m_cnt));
    chk("double_click", 32'(double_click), 32'(m_dbl));
  endtask

  // Drive s at the falling edge, let the rising edge sample it, then compare just after
  task automatic step(input bit sv);
    @(negedge clk);
    s     = sv;
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(sv);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #10;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
  endtask

  bit exp_dbl;

  initial begin
    model_reset();
`ifdef DOUBLE_CLICK_EN
    exp_dbl = 1;
`else
    exp_dbl = 0;
`endif

    // Reset held with s high while the clock runs
    s = 1'b1;
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all();
    end
    step(1);
    chk("t1_first_press", 32'(press), 32'd1);
    chk("t1_count", 32'(count), 32'd1);
    step(0);

    // Short press: two high edges
    repeat (20) step(0);
    step(1);
    chk("t2_press", 32'(press), 32'd1);
    step(1);
    chk("t2_held", 32'(held), 32'd1);
    step(0);
    chk("t2_release", 32'(release_p), 32'd1);
    chk("t2_long_never", 32'(long_press), 32'd0);
    chk("t2_count", 32'(count), 32'd2);

    // Long press: six high edges
    repeat (20) step(0);
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk("t3_long_edge", 32'(long_press), (i == 4) ? 32'd1 : 32'd0);
      chk("t3_held", 32'(held), 32'd1);
    end
    step(0);
    chk("t3_release", 32'(release_p), 32'd1);
    chk("t3_count", 32'(count), 32'd3);

    // Double click inside the window, outside it, and after a long press
    repeat (20) step(0);
    step(1);
    repeat (3) step(0);
    step(1);
    chk("t5_dbl_quick", 32'(double_click), 32'(exp_dbl));
    step(0);
    repeat (20) step(0);
    step(1);
    chk("t5_dbl_gap", 32'(double_click), 32'd0);
    repeat (4) step(1);
    repeat (2) step(0);
    step(1);
    chk("t5_dbl_after_long", 32'(double_click), 32'd0);
    step(0);

    // Asynchronous reset in the middle of a hold (timer at 2)
    repeat (20) step(0);
    step(1);
    step(1);
    async_reset();
    chk("t6_held_zero", 32'(held), 32'd0);
    chk("t6_count_zero", 32'(count), 32'd0);
    repeat (8) begin
      step(0);
      chk("t6_no_release", 32'(release_p), 32'd0);
      chk("t6_no_long", 32'(long_press), 32'd0);
    end

    // Many quick presses to take the counter through its wrap
    for (int i = 0; i < 300; i++) begin
      step(1);
      step(0);
    end

    // Random traffic with runs of varied length and occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 24))
                                         : int'($urandom_range(1, 7));
      for (int j = 0; j < len; j++) step(lvl);
      if ($urandom_range(0, 39) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
